// File: rtl/rv_pkg.sv
// Shared RV64 decode definitions: widths, major opcodes and immediate formats.
package rv_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int RIDX_W = 5;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32,
      OPC_JALR, OPC_SYSTEM:                 fmt = IMM_I;
      OPC_STORE:                            fmt = IMM_S;
      OPC_BRANCH:                           fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:                   fmt = IMM_U;
      OPC_JAL:                              fmt = IMM_J;
      default:                              fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/register_file.sv
// Integer register file: two combinational read ports with write-through, one write port, x0 fixed at zero.
module register_file
  import rv_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        wr_en,
  input  logic [RIDX_W-1:0]           wr_addr,
  input  logic [XLEN-1:0]             wr_data,
  input  logic [1:0][RIDX_W-1:0]      rd_addr,
  output logic [1:0][XLEN-1:0]        rd_data
);

  logic [XLEN-1:0] regs_reg [NREG];
  logic            wr_fire;

  assign wr_fire = wr_en && (wr_addr != '0);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
    end else if (wr_fire) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
    always_comb begin
      if (rd_addr[gi] == '0)
        rd_data[gi] = '0;
      else if (wr_fire && (wr_addr == rd_addr[gi]))
        rd_data[gi] = wr_data;
      else
        rd_data[gi] = regs_reg[rd_addr[gi]];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field/immediate decode, operand read, scoreboard hazard detection, EXE latch launch.
module decode_stage
  import rv_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               DE_V,
  input  logic [XLEN-1:0]    DE_NPC,
  input  logic [31:0]        DE_IR,
  input  logic               WB_V,
  input  logic [RIDX_W-1:0]  WB_RD,
  input  logic [XLEN-1:0]    WB_DATA,
  output logic               V_DEP_STALL,
  output logic               V_DE_FE_BR_STALL,
  output logic               EXE_V,
  output logic [XLEN-1:0]    EXE_NPC,
  output logic [31:0]        EXE_IR,
  output logic [XLEN-1:0]    EXE_RS1_VAL,
  output logic [XLEN-1:0]    EXE_RS2_VAL,
  output logic [XLEN-1:0]    EXE_IMM,
  output logic [RIDX_W-1:0]  EXE_RD
);

  logic [6:0]              opcode;
  logic [RIDX_W-1:0]       rd, rs1, rs2;
  logic                    uses_rs1, uses_rs2, writes_rd, issue;
  imm_fmt_e                imm_fmt;
  logic [XLEN-1:0]         imm_val;
  logic [1:0][XLEN-1:0]    rf_data;
  logic [NREG-1:0]         busy_reg, busy_next, clr, eff_busy;

  assign opcode = DE_IR[6:0];
  assign rd     = DE_IR[11:7];
  assign rs1    = DE_IR[19:15];
  assign rs2    = DE_IR[24:20];

  assign uses_rs1  = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign uses_rs2  = opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP, OPC_OP_32};
  assign writes_rd = !(opcode inside {OPC_BRANCH, OPC_STORE}) && (rd != '0);
  assign imm_fmt   = imm_format(opcode);

  always_comb begin
    imm_val = '0;
    case (imm_fmt)
      IMM_I: imm_val = {{(XLEN-12){DE_IR[31]}}, DE_IR[31:20]};
      IMM_S: imm_val = {{(XLEN-12){DE_IR[31]}}, DE_IR[31:25], DE_IR[11:7]};
      IMM_B: imm_val = {{(XLEN-13){DE_IR[31]}}, DE_IR[31], DE_IR[7], DE_IR[30:25], DE_IR[11:8], 1'b0};
      IMM_U: imm_val = {{(XLEN-32){DE_IR[31]}}, DE_IR[31:12], 12'b0};
      IMM_J: imm_val = {{(XLEN-21){DE_IR[31]}}, DE_IR[31], DE_IR[19:12], DE_IR[20], DE_IR[30:21], 1'b0};
      default: imm_val = '0;
    endcase
  end

  register_file u_register_file (
    .CLK     (CLK),
    .RESET   (RESET),
    .wr_en   (WB_V),
    .wr_addr (WB_RD),
    .wr_data (WB_DATA),
    .rd_addr ({rs2, rs1}),
    .rd_data (rf_data)
  );

  // A writeback in the same cycle frees its register before the hazard check.
  assign clr      = WB_V ? (NREG'(1) << WB_RD) : '0;
  assign eff_busy = busy_reg & ~clr;

  assign V_DEP_STALL = DE_V && ((uses_rs1 && eff_busy[rs1]) ||
                                (uses_rs2 && eff_busy[rs2]) ||
                                (writes_rd && eff_busy[rd]));
  assign V_DE_FE_BR_STALL = DE_V && (opcode inside {OPC_BRANCH, OPC_JAL, OPC_JALR});
  assign issue = DE_V && !V_DEP_STALL;

  assign busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
    assign busy_next[gi] = eff_busy[gi] || (issue && writes_rd && (rd == RIDX_W'(gi)));
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      busy_reg    <= '0;
      EXE_V       <= 1'b0;
      EXE_NPC     <= '0;
      EXE_IR      <= '0;
      EXE_RS1_VAL <= '0;
      EXE_RS2_VAL <= '0;
      EXE_IMM     <= '0;
      EXE_RD      <= '0;
    end else begin
      busy_reg <= busy_next;
      EXE_V    <= issue;
      if (issue) begin
        EXE_NPC     <= DE_NPC;
        EXE_IR      <= DE_IR;
        EXE_RS1_VAL <= rf_data[0];
        EXE_RS2_VAL <= rf_data[1];
        EXE_IMM     <= imm_val;
        EXE_RD      <= writes_rd ? rd : '0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        DE_V = 1'b0;
  logic [63:0] DE_NPC = '0;
  logic [31:0] DE_IR = '0;
  logic        WB_V = 1'b0;
  logic [4:0]  WB_RD = '0;
  logic [63:0] WB_DATA = '0;
  logic        V_DEP_STALL, V_DE_FE_BR_STALL, EXE_V;
  logic [63:0] EXE_NPC, EXE_RS1_VAL, EXE_RS2_VAL, EXE_IMM;
  logic [31:0] EXE_IR;
  logic [4:0]  EXE_RD;

  always #5 CLK = ~CLK;

  decode_stage dut (
    .CLK(CLK), .RESET(RESET), .DE_V(DE_V), .DE_NPC(DE_NPC), .DE_IR(DE_IR),
    .WB_V(WB_V), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
    .V_DEP_STALL(V_DEP_STALL), .V_DE_FE_BR_STALL(V_DE_FE_BR_STALL),
    .EXE_V(EXE_V), .EXE_NPC(EXE_NPC), .EXE_IR(EXE_IR),
    .EXE_RS1_VAL(EXE_RS1_VAL), .EXE_RS2_VAL(EXE_RS2_VAL),
    .EXE_IMM(EXE_IMM), .EXE_RD(EXE_RD)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  logic [63:0] m_regs [32];
  bit   [31:0] m_busy;
  logic        e_v;
  logic [63:0] e_npc, e_rs1, e_rs2, e_imm;
  logic [31:0] e_ir;
  logic [4:0]  e_rd;
  logic        x_dep, x_br, x_issue;
  logic [63:0] x_rs1, x_rs2;

  logic [6:0] ops [13] = '{7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h33, 7'h13,
                           7'h3b, 7'h1b, 7'h37, 7'h17, 7'h73, 7'h7f};

  function automatic bit m_uses1(input logic [6:0] op);
    return !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
  endfunction

  function automatic bit m_uses2(input logic [6:0] op);
    return (op == 7'h63 || op == 7'h23 || op == 7'h33 || op == 7'h3b);
  endfunction

  function automatic bit m_writes(input logic [31:0] ir);
    return !(ir[6:0] == 7'h63 || ir[6:0] == 7'h23) && (ir[11:7] != 5'd0);
  endfunction

  function automatic logic [63:0] m_imm(input logic [31:0] ir);
    longint v;
    v = $signed(ir);
    case (ir[6:0])
      7'h03, 7'h13, 7'h1b, 7'h67, 7'h73: return v >>> 20;
      7'h23: return ((v >>> 25) << 5) | longint'(ir[11:7]);
      7'h63: return ((v >>> 31) << 12) | (longint'(ir[7]) << 11) |
                    (longint'(ir[30:25]) << 5) | (longint'(ir[11:8]) << 1);
      7'h37, 7'h17: return (v >>> 12) << 12;
      7'h6f: return ((v >>> 31) << 20) | (longint'(ir[19:12]) << 12) |
                    (longint'(ir[20]) << 11) | (longint'(ir[30:21]) << 1);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 64'd0;
    if (WB_V && WB_RD == r) return WB_DATA;
    return m_regs[r];
  endfunction

  function automatic bit m_eff_busy(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !(WB_V && WB_RD == r);
  endfunction

  task automatic predict();
    logic [6:0] op;
    op = DE_IR[6:0];
    x_dep = DE_V && ((m_uses1(op) && m_eff_busy(DE_IR[19:15])) ||
                     (m_uses2(op) && m_eff_busy(DE_IR[24:20])) ||
                     (m_writes(DE_IR) && m_eff_busy(DE_IR[11:7])));
    x_br = DE_V && (op == 7'h63 || op == 7'h6f || op == 7'h67);
    x_issue = DE_V && !x_dep;
    x_rs1 = m_read(DE_IR[19:15]);
    x_rs2 = m_read(DE_IR[24:20]);
  endtask

  task automatic drive(input logic dv, input logic [63:0] npc, input logic [31:0] ir,
                       input logic wv, input logic [4:0] wr, input logic [63:0] wd);
    @(negedge CLK);
    DE_V = dv; DE_NPC = npc; DE_IR = ir;
    WB_V = wv; WB_RD = wr; WB_DATA = wd;
    predict();
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    predict();
    if (!RESET) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0;
      e_v = 0; e_npc = '0; e_ir = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_rd = '0;
    end else begin
      if (x_issue) begin
        e_npc = DE_NPC; e_ir = DE_IR; e_rs1 = x_rs1; e_rs2 = x_rs2;
        e_imm = m_imm(DE_IR);
        e_rd  = m_writes(DE_IR) ? DE_IR[11:7] : 5'd0;
      end
      e_v = x_issue;
      if (WB_V) m_busy[WB_RD] = 1'b0;
      if (x_issue && m_writes(DE_IR)) m_busy[DE_IR[11:7]] = 1'b1;
      m_busy[0] = 1'b0;
      if (WB_V && WB_RD != 5'd0) m_regs[WB_RD] = WB_DATA;
    end
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    drive(1, 64'h100, 32'hFFF00293, 1, 5'd5, 64'hAA);
    tick();
    drive(1, 64'h104, 32'hFFF00293, 1, 5'd5, 64'hBB);
    tick();
    n_cmp++; if (EXE_V !== 1'b0) begin n_err++; $display("FAIL reset_exe_v got %b exp 0", EXE_V); end
    n_cmp++; if (EXE_IR !== 32'h0) begin n_err++; $display("FAIL reset_exe_ir got %h exp 0", EXE_IR); end
    n_cmp++; if (V_DEP_STALL !== 1'b0) begin n_err++; $display("FAIL reset_dep got %b exp 0", V_DEP_STALL); end
    n_cmp++; if (V_DE_FE_BR_STALL !== 1'b0) begin n_err++; $display("FAIL reset_br got %b exp 0", V_DE_FE_BR_STALL); end
    RESET = 1'b1;
    // ADD x7,x5,x5: x5 must read 0 after reset despite WB presented during it
    drive(1, 64'h108, 32'h005283B3, 0, 5'd0, 64'h0);
    n_cmp++; if (V_DEP_STALL !== 1'b0) begin n_err++; $display("FAIL reset_busy_clear got %b exp 0", V_DEP_STALL); end
    tick();
    n_cmp++; if (EXE_RS1_VAL !== 64'h0) begin n_err++; $display("FAIL reset_x5_read got %h exp 0", EXE_RS1_VAL); end
    $display("test_reset done");
  endtask

  task automatic test_addi();
    drive(1, 64'h200, 32'hFFF00293, 0, 5'd0, 64'h0);
    tick();
    n_cmp++; if (EXE_V !== 1'b1) begin n_err++; $display("FAIL addi_v got %b exp 1", EXE_V); end
    n_cmp++; if (EXE_IMM !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL addi_imm got %h exp all ones", EXE_IMM); end
    n_cmp++; if (EXE_RD !== 5'd5) begin n_err++; $display("FAIL addi_rd got %0d exp 5", EXE_RD); end
    n_cmp++; if (EXE_NPC !== 64'h200) begin n_err++; $display("FAIL addi_npc got %h exp 200", EXE_NPC); end
    $display("test_addi done");
  endtask

  task automatic test_raw();
    for (int c = 0; c < 3; c++) begin
      drive(1, 64'h204, 32'h00528333, 0, 5'd0, 64'h0);
      n_cmp++; if (V_DEP_STALL !== 1'b1) begin n_err++; $display("FAIL raw_stall[%0d] got %b exp 1", c, V_DEP_STALL); end
      tick();
      n_cmp++; if (EXE_V !== 1'b0) begin n_err++; $display("FAIL raw_bubble[%0d] got %b exp 0", c, EXE_V); end
    end
    drive(1, 64'h204, 32'h00528333, 1, 5'd5, 64'd7);
    n_cmp++; if (V_DEP_STALL !== 1'b0) begin n_err++; $display("FAIL raw_release got %b exp 0", V_DEP_STALL); end
    tick();
    n_cmp++; if (EXE_V !== 1'b1) begin n_err++; $display("FAIL raw_issue got %b exp 1", EXE_V); end
    n_cmp++; if (EXE_RS1_VAL !== 64'd7) begin n_err++; $display("FAIL raw_rs1 got %h exp 7", EXE_RS1_VAL); end
    n_cmp++; if (EXE_RS2_VAL !== 64'd7) begin n_err++; $display("FAIL raw_rs2 got %h exp 7", EXE_RS2_VAL); end
    $display("test_raw done");
  endtask

  task automatic test_branch();
    drive(1, 64'h300, 32'h00208863, 0, 5'd0, 64'h0);
    n_cmp++; if (V_DE_FE_BR_STALL !== 1'b1) begin n_err++; $display("FAIL br_stall got %b exp 1", V_DE_FE_BR_STALL); end
    tick();
    n_cmp++; if (EXE_IMM !== 64'd16) begin n_err++; $display("FAIL br_imm got %h exp 10", EXE_IMM); end
    n_cmp++; if (EXE_RD !== 5'd0) begin n_err++; $display("FAIL br_rd got %0d exp 0", EXE_RD); end
    // ADDI x11,x16,0: x16 is the branch's rd field and must not be busy
    drive(1, 64'h304, 32'h00080593, 0, 5'd0, 64'h0);
    n_cmp++; if (V_DEP_STALL !== 1'b0) begin n_err++; $display("FAIL br_no_busy got %b exp 0", V_DEP_STALL); end
    tick();
    $display("test_branch done");
  endtask

  task automatic test_x0();
    drive(1, 64'h400, 32'h00500013, 0, 5'd0, 64'h0);
    n_cmp++; if (V_DEP_STALL !== 1'b0) begin n_err++; $display("FAIL x0_stall got %b exp 0", V_DEP_STALL); end
    tick();
    n_cmp++; if (EXE_RD !== 5'd0) begin n_err++; $display("FAIL x0_rd got %0d exp 0", EXE_RD); end
    drive(1, 64'h404, 32'h000004B3, 1, 5'd0, 64'd9);
    n_cmp++; if (V_DEP_STALL !== 1'b0) begin n_err++; $display("FAIL x0_wb_stall got %b exp 0", V_DEP_STALL); end
    tick();
    n_cmp++; if (EXE_RS1_VAL !== 64'd0) begin n_err++; $display("FAIL x0_read_wt got %h exp 0", EXE_RS1_VAL); end
    drive(1, 64'h408, 32'h000004B3, 0, 5'd0, 64'd0);
    tick();
    n_cmp++; if (EXE_RS2_VAL !== 64'd0) begin n_err++; $display("FAIL x0_read_after got %h exp 0", EXE_RS2_VAL); end
    $display("test_x0 done");
  endtask

  task automatic test_collision();
    drive(1, 64'h500, 32'h00100193, 0, 5'd0, 64'h0);
    tick();
    drive(1, 64'h504, 32'h00118193, 1, 5'd3, 64'h1234);
    n_cmp++; if (V_DEP_STALL !== 1'b0) begin n_err++; $display("FAIL coll_stall got %b exp 0", V_DEP_STALL); end
    tick();
    n_cmp++; if (EXE_RS1_VAL !== 64'h1234) begin n_err++; $display("FAIL coll_rs1 got %h exp 1234", EXE_RS1_VAL); end
    drive(1, 64'h508, 32'h00018533, 0, 5'd0, 64'h0);
    n_cmp++; if (V_DEP_STALL !== 1'b1) begin n_err++; $display("FAIL coll_busy_kept got %b exp 1", V_DEP_STALL); end
    tick();
    drive(0, 64'h0, 32'h0, 1, 5'd3, 64'd5);
    n_cmp++; if (V_DEP_STALL !== 1'b0 || V_DE_FE_BR_STALL !== 1'b0) begin
      n_err++; $display("FAIL devalid0_stalls got %b%b exp 00", V_DEP_STALL, V_DE_FE_BR_STALL);
    end
    tick();
    $display("test_collision done");
  endtask

  task automatic test_random();
    logic [31:0] ir;
    logic [4:0]  wr;
    logic        dv, wv;
    for (int t = 0; t < 400; t++) begin
      ir = $urandom;
      ir[6:0]   = ops[$urandom_range(0, 12)];
      ir[11:7]  = 5'($urandom_range(0, 7));
      ir[19:15] = 5'($urandom_range(0, 7));
      ir[24:20] = 5'($urandom_range(0, 7));
      dv = ($urandom_range(0, 9) < 8);
      wv = ($urandom_range(0, 9) < 5);
      wr = 5'($urandom_range(0, 7));
      if (m_busy[7:1] != 7'd0 && $urandom_range(0, 3) != 0) begin
        do wr = 5'($urandom_range(1, 7)); while (!m_busy[wr]);
      end
      RESET = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      drive(dv, {$urandom, $urandom}, ir, wv, wr, {$urandom, $urandom});
      n_cmp++; if (V_DEP_STALL !== x_dep) begin n_err++; $display("FAIL rnd_dep[%0d] got %b exp %b", t, V_DEP_STALL, x_dep); end
      n_cmp++; if (V_DE_FE_BR_STALL !== x_br) begin n_err++; $display("FAIL rnd_br[%0d] got %b exp %b", t, V_DE_FE_BR_STALL, x_br); end
      tick();
      $display("rnd %0d rst=%b de_v=%b ir=%h wb=%b/%0d -> exe_v=%b rd=%0d imm=%h", t, RESET, dv, ir, wv, wr, EXE_V, EXE_RD, EXE_IMM);
      n_cmp++; if (EXE_V !== e_v) begin n_err++; $display("FAIL rnd_v[%0d] got %b exp %b", t, EXE_V, e_v); end
      n_cmp++; if (EXE_NPC !== e_npc || EXE_IR !== e_ir) begin
        n_err++; $display("FAIL rnd_npc_ir[%0d] got %h/%h exp %h/%h", t, EXE_NPC, EXE_IR, e_npc, e_ir);
      end
      n_cmp++; if (EXE_RS1_VAL !== e_rs1 || EXE_RS2_VAL !== e_rs2) begin
        n_err++; $display("FAIL rnd_ops[%0d] got %h/%h exp %h/%h", t, EXE_RS1_VAL, EXE_RS2_VAL, e_rs1, e_rs2);
      end
      n_cmp++; if (EXE_IMM !== e_imm) begin n_err++; $display("FAIL rnd_imm[%0d] got %h exp %h", t, EXE_IMM, e_imm); end
      n_cmp++; if (EXE_RD !== e_rd) begin n_err++; $display("FAIL rnd_rd[%0d] got %0d exp %0d", t, EXE_RD, e_rd); end
    end
    RESET = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
    e_v = 0; e_npc = '0; e_ir = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_rd = '0;
    test_reset();
    test_addi();
    test_raw();
    test_branch();
    test_x0();
    test_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Consumer end of the fetch→decode latch interface.
- Takes DE_V/DE_NPC/DE_IR and reads operands from an internal register file.
- Generates immediates and launches the EXE latch.
- Drives V_DEP_STALL (scoreboard hazard) and V_DE_FE_BR_STALL (control-transfer in decode) back to fetch. Fetch uses these to hold its PC and DE latch.

Parameters:
XLEN, 64, datapath and register width
NREG, 32, architectural integer registers; index width 5 bits

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous reset, active-low; takes effect on the CLK edge while RESET==0
DE_V  in  1  decode latch valid
DE_NPC  in  XLEN  PC+4 of the instruction in decode
DE_IR  in  32  instruction in decode
WB_V  in  1  writeback valid
WB_RD  in  5  writeback destination
WB_DATA  in  XLEN  writeback value
V_DEP_STALL  out  1  RAW/WAW hazard; fetch holds its DE latch
V_DE_FE_BR_STALL  out  1  branch/jump in decode; fetch holds PC and invalidates
EXE_V  out  1  execute latch valid
EXE_NPC  out  XLEN  copied DE_NPC
EXE_IR  out  32  copied DE_IR
EXE_RS1_VAL  out  XLEN  rs1 operand
EXE_RS2_VAL  out  XLEN  rs2 operand
EXE_IMM  out  XLEN  sign-extended immediate
EXE_RD  out  5  destination; 0 when the instruction does not write

Behaviour:
- Field decode: opcode=IR[6:0], rd=IR[11:7], rs1=IR[19:15], rs2=IR[24:20].
- uses_rs1: every opcode except LUI, AUIPC, JAL.
- uses_rs2: BRANCH, STORE, OP, OP-32.
- writes_rd: every opcode except BRANCH and STORE, and only when rd!=0.
- Immediates, sign-extended from the top instruction bit to XLEN:
  - I: loads, OP-IMM, OP-IMM-32, JALR, SYSTEM.
  - S: STORE.
  - B: BRANCH, bit0=0.
  - U: LUI, AUIPC, low 12 bits zero.
  - J: JAL, bit0=0.
  - Unknown opcode: IMM=0.
- Register file: NREG×XLEN, 2 combinational read ports, 1 write port.
  - Written on WB_V && WB_RD!=0.
  - x0 reads 0 always.
  - Same-cycle write-through: a read of WB_RD returns WB_DATA.
- Scoreboard: busy[31:0]; busy[0] is hard-wired 0.
  - clr = WB_V ? onehot(WB_RD) : 0.
  - eff_busy = busy & ~clr.
- Hazard: V_DEP_STALL = DE_V && ((uses_rs1 && eff_busy[rs1]) || (uses_rs2 && eff_busy[rs2]) || (writes_rd && eff_busy[rd])). The last term covers WAW. Combinational.
- Issue: issue = DE_V && !V_DEP_STALL.
- V_DE_FE_BR_STALL = DE_V && opcode ∈ {BRANCH, JAL, JALR}. Combinational. Held while a dep stall is also active.
- Scoreboard next state:
  - busy_next = (busy & ~clr) | (issue && writes_rd ? onehot(rd) : 0).
  - Set wins over clear for the same register in the same cycle.
- EXE latch, every cycle:
  - EXE_V <= issue.
  - When issue, load NPC, IR, operands, IMM, EXE_RD.
  - When not issue, data fields hold their old values and only EXE_V drops (bubble). Latency is 1 cycle from DE to EXE.
- Reset (RESET==0 at edge):
  - EXE_V=0, EXE_NPC=0, EXE_IR=0 (NOP is not required), EXE_RS1_VAL=0, EXE_RS2_VAL=0, EXE_IMM=0, EXE_RD=0.
  - busy=0; all registers =0.
  - Reset mid-stall drops any pending instruction.
  - WB writes presented during reset are ignored.
- DE_V=0: both stall outputs are 0 and there is no issue, whatever DE_IR holds.
- The scoreboard never issues a second writer to a busy rd, so one busy bit per register is sufficient.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32, OPC_LUI, OPC_AUIPC, OPC_SYSTEM);
  - XLEN;
  - an immediate-format enum (IMM_I/S/B/U/J/NONE).
- Sub-module register_file: 2R1W, write-through, x0=0, synchronous active-low reset. The scoreboard and immediate generation stay in decode_stage.

Test Plan:
- Reset: hold RESET=0 for 2 cycles with DE_V=1 → EXE_V=0, both stalls 0, busy=0, read of x5 returns 0.
- ADDI x5,x0,-1 (IR=0xFFF00293) with DE_V=1 → next cycle EXE_V=1, EXE_IMM=0xFFFF_FFFF_FFFF_FFFF, EXE_RD=5; busy[5]=1.
- RAW: next instruction ADD x6,x5,x5 → V_DEP_STALL=1 and EXE_V=0 each cycle until WB_V=1, WB_RD=5, WB_DATA=7. In that WB cycle there is no stall, and ADD issues with RS1_VAL=RS2_VAL=7.
- BEQ x1,x2,+16 (IR=0x00208863) → V_DE_FE_BR_STALL=1 the same cycle; EXE_IMM=16; EXE_RD=0; no busy bit set.
- Write to x0: ADDI x0,x0,5, then WB_V=1 with WB_RD=0, WB_DATA=9 → no busy set, no stall, a subsequent read of x0 returns 0.
- Set/clear collision: busy[3]=1, WB frees x3 while ADDI x3,x3,1 is in decode → no stall; RS1_VAL=WB_DATA; busy[3] remains 1 after the edge.
